// File: rtl/sram_march_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_march_bist_pkg
// Description : Shared definitions for the March C- SRAM BIST: controller
//               state encoding, march element indices E0..E5 and the
//               per-element operation table (direction, op count, op kinds
//               and data values).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_march_bist_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // March element indices.
    localparam logic [2:0] c_E0 = 3'd0;
    localparam logic [2:0] c_E1 = 3'd1;
    localparam logic [2:0] c_E2 = 3'd2;
    localparam logic [2:0] c_E3 = 3'd3;
    localparam logic [2:0] c_E4 = 3'd4;
    localparam logic [2:0] c_E5 = 3'd5;

    // One march element: address direction, ops per address (1 or 2) and,
    // for each op slot, whether it is a read and which data value (0/1) it
    // writes or expects.
    typedef struct packed {
        logic       down;
        logic [1:0] n_ops;
        logic       op0_rd;
        logic       op0_val;
        logic       op1_rd;
        logic       op1_val;
    } elem_cfg_t;

    // March C-:
    //   E0 up(w0); E1 up(r0,w1); E2 up(r1,w0);
    //   E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t cfg;
        cfg = '0;
        case (elem)
            c_E0: cfg = '{down: 1'b0, n_ops: 2'd1, op0_rd: 1'b0, op0_val: 1'b0, op1_rd: 1'b0, op1_val: 1'b0};
            c_E1: cfg = '{down: 1'b0, n_ops: 2'd2, op0_rd: 1'b1, op0_val: 1'b0, op1_rd: 1'b0, op1_val: 1'b1};
            c_E2: cfg = '{down: 1'b0, n_ops: 2'd2, op0_rd: 1'b1, op0_val: 1'b1, op1_rd: 1'b0, op1_val: 1'b0};
            c_E3: cfg = '{down: 1'b1, n_ops: 2'd2, op0_rd: 1'b1, op0_val: 1'b0, op1_rd: 1'b0, op1_val: 1'b1};
            c_E4: cfg = '{down: 1'b1, n_ops: 2'd2, op0_rd: 1'b1, op0_val: 1'b1, op1_rd: 1'b0, op1_val: 1'b0};
            c_E5: cfg = '{down: 1'b0, n_ops: 2'd1, op0_rd: 1'b1, op0_val: 1'b0, op1_rd: 1'b0, op1_val: 1'b0};
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

    // Direction of an element, used to pick the start address of the next one.
    function automatic logic elem_is_down(input logic [2:0] elem);
        elem_cfg_t cfg;
        cfg = elem_cfg(elem);
        return cfg.down;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_cmp
// Description : Read-data checker for the March BIST. A read issued in one
//               cycle registers its expected word here; the next cycle that
//               word is compared against the SRAM's registered read data and
//               any difference sets a sticky fail flag.
//               With SRAM_BIST_FAIL_LOG_EN defined, the address, element and
//               differing bits of the first mismatch are also captured.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_clear         - clear flag/log (test start)
//               i_rd_issue      - a read op is on the SRAM port this cycle
//               i_exp_data      - word that read should return
//               i_dout          - SRAM read data (valid cycle after read)
//               i_addr, i_elem  - read address/element (fail log only)
//               o_fail          - sticky mismatch flag
//               o_fail_addr/elem/bits - first-mismatch log (fail log only)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bist_cmp #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_rd_issue,
    input  logic [P_DATA_WIDTH-1:0] i_exp_data,
    input  logic [P_DATA_WIDTH-1:0] i_dout,
`ifdef SRAM_BIST_FAIL_LOG_EN
    input  logic [P_ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]              i_elem,
    output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
    output logic [2:0]              o_fail_elem,
    output logic [P_DATA_WIDTH-1:0] o_fail_bits,
`endif
    output logic                    o_fail
);

    logic                    r_exp_valid;
    logic [P_DATA_WIDTH-1:0] r_exp_data;
    logic                    r_fail;
    logic [P_DATA_WIDTH-1:0] w_diff;
    logic                    w_mismatch;

    assign w_diff     = r_exp_data ^ i_dout;
    assign w_mismatch = r_exp_valid && (|w_diff);
    assign o_fail     = r_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_valid <= 1'b0;
            r_exp_data  <= '0;
            r_fail      <= 1'b0;
        end else if (i_clear) begin
            r_exp_valid <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_exp_valid <= i_rd_issue;
            if (i_rd_issue) begin
                r_exp_data <= i_exp_data;
            end
            if (w_mismatch) begin
                r_fail <= 1'b1;
            end
        end
    end

`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [P_ADDR_WIDTH-1:0] r_exp_addr;
    logic [2:0]              r_exp_elem;
    logic [P_ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]              r_fail_elem;
    logic [P_DATA_WIDTH-1:0] r_fail_bits;

    // Only the first mismatch of a run is logged: later ones find r_fail set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_addr  <= '0;
            r_exp_elem  <= '0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
        end else if (i_clear) begin
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
        end else begin
            if (i_rd_issue) begin
                r_exp_addr <= i_addr;
                r_exp_elem <= i_elem;
            end
            if (w_mismatch && !r_fail) begin
                r_fail_addr <= r_exp_addr;
                r_fail_elem <= r_exp_elem;
                r_fail_bits <= w_diff;
            end
        end
    end

    assign o_fail_addr = r_fail_addr;
    assign o_fail_elem = r_fail_elem;
    assign o_fail_bits = r_fail_bits;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : sram_march_bist
// Description : March C- BIST controller for a single-port SRAM BIST port.
//               One SRAM op per cycle, 10*N ops per run, then one drain
//               cycle for the final read compare, then DONE.
//               Optional feature macro: SRAM_BIST_FAIL_LOG_EN adds the
//               first-mismatch log outputs A_FAIL_ADDR/ELEM/BITS.
// Ports       : A_CLK, A_RST        - clock, asynchronous active-high reset
//               A_START             - test request (accepted in IDLE/DONE)
//               A_BUSY, A_DONE      - run status
//               A_FAIL              - sticky mismatch flag
//               A_BIST_EN           - selects the SRAM BIST port
//               A_BIST_ADDR/DIN/BM  - SRAM address, write data, bit mask
//               A_BIST_MEN/WEN/REN  - SRAM memory/write/read enables
//               A_DOUT              - SRAM registered read data
//               A_FAIL_ADDR/ELEM/BITS - first mismatch (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_march_bist
    import sram_march_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 6
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic                    A_BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
`ifdef SRAM_BIST_FAIL_LOG_EN
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS,
`endif
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_LAST = '1;
    localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

    bist_state_t             r_state;
    bist_state_t             w_state_n;
    logic [2:0]              r_elem;
    logic [2:0]              w_elem_n;
    logic                    r_op;
    logic                    w_op_n;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_ADDR_WIDTH-1:0] w_addr_n;

    elem_cfg_t               w_cfg;
    logic                    w_next_down;
    logic                    w_op_rd;
    logic                    w_op_val;
    logic                    w_last_op;
    logic                    w_last_addr;
    logic                    w_start_accept;
    logic                    w_rd_issue;
    logic [P_DATA_WIDTH-1:0] w_op_word;

    assign w_cfg       = elem_cfg(r_elem);
    assign w_next_down = elem_is_down(r_elem + 3'd1);
    assign w_op_rd     = r_op ? w_cfg.op1_rd  : w_cfg.op0_rd;
    assign w_op_val    = r_op ? w_cfg.op1_val : w_cfg.op0_val;
    assign w_op_word   = {P_DATA_WIDTH{w_op_val}};
    assign w_last_op   = ({1'b0, r_op} == (w_cfg.n_ops - 2'd1));
    assign w_last_addr = w_cfg.down ? (r_addr == '0) : (r_addr == c_ADDR_LAST);
    assign A_DONE      = (r_state == ST_DONE);

    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            r_state <= ST_IDLE;
            r_elem  <= c_E0;
            r_op    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_n;
            r_elem  <= w_elem_n;
            r_op    <= w_op_n;
            r_addr  <= w_addr_n;
        end
    end

    // Ops are presented straight from the registered element/op/address
    // counters, so the op for a cycle is fully determined by state alone and
    // an asynchronous reset kills the SRAM enables within the same cycle.
    always_comb begin
        w_state_n      = r_state;
        w_elem_n       = r_elem;
        w_op_n         = r_op;
        w_addr_n       = r_addr;
        w_start_accept = 1'b0;
        w_rd_issue     = 1'b0;
        A_BUSY         = 1'b0;
        A_BIST_EN      = 1'b0;
        A_BIST_BM      = '0;
        A_BIST_DIN     = '0;
        A_BIST_MEN     = 1'b0;
        A_BIST_WEN     = 1'b0;
        A_BIST_REN     = 1'b0;
        A_BIST_ADDR    = '0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (A_START) begin
                    w_start_accept = 1'b1;
                    w_state_n      = ST_RUN;
                    w_elem_n       = c_E0;
                    w_op_n         = 1'b0;
                    w_addr_n       = '0;
                end
            end

            ST_RUN: begin
                A_BUSY      = 1'b1;
                A_BIST_EN   = 1'b1;
                A_BIST_BM   = '1;
                A_BIST_MEN  = 1'b1;
                A_BIST_WEN  = !w_op_rd;
                A_BIST_REN  = w_op_rd;
                A_BIST_ADDR = r_addr;
                A_BIST_DIN  = w_op_rd ? '0 : w_op_word;
                w_rd_issue  = w_op_rd;

                if (!w_last_op) begin
                    w_op_n = r_op + 1'b1;
                end else begin
                    w_op_n = 1'b0;
                    if (!w_last_addr) begin
                        w_addr_n = w_cfg.down ? (r_addr - c_ADDR_ONE) : (r_addr + c_ADDR_ONE);
                    end else if (r_elem == c_E5) begin
                        w_state_n = ST_DRAIN;
                    end else begin
                        // Jump straight to the next element's first address.
                        w_elem_n = r_elem + 3'd1;
                        w_addr_n = w_next_down ? c_ADDR_LAST : '0;
                    end
                end
            end

            ST_DRAIN: begin
                // No op this cycle; the final E5 read is compared here.
                A_BUSY    = 1'b1;
                A_BIST_EN = 1'b1;
                A_BIST_BM = '1;
                w_state_n = ST_DONE;
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    sram_bist_cmp #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_cmp (
        .clk         (A_CLK),
        .rst         (A_RST),
        .i_clear     (w_start_accept),
        .i_rd_issue  (w_rd_issue),
        .i_exp_data  (w_op_word),
        .i_dout      (A_DOUT),
`ifdef SRAM_BIST_FAIL_LOG_EN
        .i_addr      (r_addr),
        .i_elem      (r_elem),
        .o_fail_addr (A_FAIL_ADDR),
        .o_fail_elem (A_FAIL_ELEM),
        .o_fail_bits (A_FAIL_BITS),
`endif
        .o_fail      (A_FAIL)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_march_bist
// Description : Scoreboard bench for sram_march_bist (N=16, 8-bit words).
//               The stimulus side builds the full March C- op trace and the
//               final result from a plain-loop reference model and queues
//               them; a monitor pops and compares each SRAM op and the DONE
//               result as the DUT presents them. A behavioural SRAM with an
//               optional stuck-at fault answers the reads.
//               Cycle numbering: the period after edge k is cycle k+1, and
//               cyc holds k during that period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int N   = 16;
    localparam int OPS = 10 * N;

    // March C- description. Op codes: 0=w0 1=w1 2=r0 3=r1.
    localparam int E_DOWN [6]    = '{0, 0, 0, 1, 1, 0};
    localparam int E_NOPS [6]    = '{1, 2, 2, 2, 2, 1};
    localparam int E_OPS  [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, bist_en, men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm;
    logic [DW-1:0] dout = '0;
`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_bits;
`endif

    always #5 clk = ~clk;

    sram_march_bist #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW)
    ) dut (
        .A_CLK       (clk),
        .A_RST       (rst),
        .A_START     (start),
        .A_BUSY      (busy),
        .A_DONE      (done),
        .A_FAIL      (fail),
        .A_BIST_EN   (bist_en),
        .A_BIST_ADDR (addr),
        .A_BIST_DIN  (din),
        .A_BIST_BM   (bm),
        .A_BIST_MEN  (men),
        .A_BIST_WEN  (wen),
        .A_BIST_REN  (ren),
`ifdef SRAM_BIST_FAIL_LOG_EN
        .A_FAIL_ADDR (fail_addr),
        .A_FAIL_ELEM (fail_elem),
        .A_FAIL_BITS (fail_bits),
`endif
        .A_DOUT      (dout)
    );

    // ---------------- SRAM model with optional stuck-at fault ----------------
    logic [DW-1:0] mem [N];
    logic          f_en   = 1'b0;
    logic          f_val  = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_mask = '0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (f_en && a == f_addr)
            return f_val ? (v | f_mask) : (v & ~f_mask);
        return v;
    endfunction

    always @(posedge clk) begin
        if (men && wen) mem[addr] <= faulty(addr, (din & bm) | (mem[addr] & ~bm));
        if (men && ren) dout      <= faulty(addr, mem[addr]);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            cyc;
        logic          wen;
        logic          ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        int            cyc;
        logic          fail;
        logic [AW-1:0] faddr;
        logic [2:0]    felem;
        logic [DW-1:0] fbits;
    } res_t;

    op_t  q_ops [$];
    res_t q_res [$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk March C- over a model memory carrying the same
    // fault and queue every op plus the expected end-of-test result.
    task automatic push_run(input int t);
        logic [DW-1:0] m [N];
        logic [DW-1:0] word, act;
        res_t r;
        op_t  o;
        int   k, a, code;
        k = 0;
        r.fail = 1'b0; r.faddr = '0; r.felem = '0; r.fbits = '0;
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                a = (E_DOWN[e] != 0) ? (N - 1 - j) : j;
                for (int p = 0; p < E_NOPS[e]; p++) begin
                    code   = E_OPS[e][p];
                    word   = (code % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    o.cyc  = t + k;
                    o.wen  = (code < 2);
                    o.ren  = (code >= 2);
                    o.addr = AW'(a);
                    o.din  = (code < 2) ? word : '0;
                    q_ops.push_back(o);
                    k++;
                    if (code >= 2) begin
                        act = faulty(AW'(a), m[a]);
                        if (act != word && !r.fail) begin
                            r.fail  = 1'b1;
                            r.faddr = AW'(a);
                            r.felem = 3'(e);
                            r.fbits = word ^ act;
                        end
                    end else begin
                        m[a] = faulty(AW'(a), word);
                    end
                end
            end
        end
        r.cyc = t + OPS + 1;
        q_res.push_back(r);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        op_t  o;
        res_t r;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            chk("bist_en_vs_busy", 64'(bist_en), 64'(busy));
            if (men) begin
                if (q_ops.size() == 0) begin
                    chk("unexpected_op", 64'(1), 64'(0));
                end else begin
                    o = q_ops.pop_front();
                    chk($sformatf("op@%0d", o.cyc),
                        {18'b0, cyc[31:0], wen, ren, addr, din, bm},
                        {18'b0, o.cyc[31:0], o.wen, o.ren, o.addr, o.din, {DW{1'b1}}});
                end
            end else begin
                chk("idle_we_re", {62'b0, wen, ren}, 64'(0));
            end
            if (done && !prev_done) begin
                if (q_res.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    r = q_res.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(r.cyc));
                    chk("done_fail", 64'(fail), 64'(r.fail));
                    chk("ops_left_at_done", 64'(q_ops.size()), 64'(0));
                    chk("busy_at_done", 64'(busy), 64'(0));
`ifdef SRAM_BIST_FAIL_LOG_EN
                    chk("log_addr", 64'(fail_addr), 64'(r.faddr));
                    chk("log_elem", 64'(fail_elem), 64'(r.felem));
                    chk("log_bits", 64'(fail_bits), 64'(r.fbits));
`endif
                end
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic hold, output int t);
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        push_run(t);
        if (!hold) start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_clears_done", 64'(done), 64'(0));
        chk("start_clears_fail", 64'(fail), 64'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < OPS + 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 64'(done), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_fault(input logic en, input int a, input int bitn, input logic v);
        f_en   = en;
        f_addr = AW'(a);
        f_mask = DW'(1) << bitn;
        f_val  = v;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin : stim
        int t;
        #1 rst = 1'b1;
        #2;
        chk("rst_outputs",
            {busy, done, fail, bist_en, men, wen, ren, addr, din, bm},
            64'(0));
`ifdef SRAM_BIST_FAIL_LOG_EN
        chk("rst_log", {fail_addr, fail_elem, fail_bits}, 64'(0));
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Clean run.
        set_fault(1'b0, 0, 0, 1'b0);
        do_start(1'b0, t);
        wait_done();
        chk("clean_fail", 64'(fail), 64'(0));

        // Bit 3 of address 5 stuck at 1: first caught by the E1 r0 at 5.
        set_fault(1'b1, 5, 3, 1'b1);
        do_start(1'b0, t);
        wait_done();
        chk("sa1_fail", 64'(fail), 64'(1));
`ifdef SRAM_BIST_FAIL_LOG_EN
        chk("sa1_addr", 64'(fail_addr), 64'(5));
        chk("sa1_elem", 64'(fail_elem), 64'(1));
        chk("sa1_bits", 64'(fail_bits), 64'(8'h08));
`endif

        // Start held high through the run: one run only.
        set_fault(1'b1, 9, 0, 1'b0);
        do_start(1'b1, t);
        repeat (OPS - 5) @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("held_single_run_ops", 64'(q_ops.size()), 64'(0));
        chk("held_still_done", 64'(done), 64'(1));
        chk("held_fail", 64'(fail), 64'(1));

        // Re-pulse in DONE: fail cleared on the accepting edge (in do_start).
        set_fault(1'b0, 0, 0, 1'b0);
        do_start(1'b0, t);
        wait_done();

        // Reset in cycle t+50 aborts immediately.
        do_start(1'b0, t);
        while (cyc < t + 49) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        q_ops.delete();
        q_res.delete();
        #1;
        chk("abort_enables", {60'b0, men, wen, ren, bist_en}, 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_start(1'b0, t);
        wait_done();
        chk("post_abort_fail", 64'(fail), 64'(0));

        // Randomised faults and start gaps.
        for (int r = 0; r < 4; r++) begin
            set_fault($urandom_range(0, 2) != 0, $urandom_range(0, N - 1),
                      $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            do_start(1'b0, t);
            wait_done();
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 Parameter P_DATA_WIDTH, default 64: SRAM word width in bits.
REQ-002 Parameter P_ADDR_WIDTH, default 6: SRAM address width; depth N = 2**P_ADDR_WIDTH.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-high reset.
REQ-004 A_CLK  in  1  sole clock; integration SHALL tie the SRAM A_BIST_CLK to it.
REQ-005 A_RST  in  1  asynchronous active-high reset.
REQ-006 A_START  in  1  one-cycle test request.
REQ-007 A_BUSY  out  1  high while a test runs.
REQ-008 A_DONE  out  1  high from test completion until the next accepted start.
REQ-009 A_FAIL  out  1  sticky mismatch flag, valid while A_DONE=1.
REQ-010 A_BIST_EN  out  1  selects the SRAM BIST port.
REQ-011 A_BIST_ADDR  out  P_ADDR_WIDTH  SRAM address.
REQ-012 A_BIST_DIN  out  P_DATA_WIDTH  write data.
REQ-013 A_BIST_BM  out  P_DATA_WIDTH  bit mask, all ones.
REQ-014 A_BIST_MEN, A_BIST_WEN, A_BIST_REN  out  1 each  memory enable, write enable, read enable.
REQ-015 A_DOUT  in  P_DATA_WIDTH  SRAM read data, registered, valid the cycle after a read.

Function
REQ-016 The block SHALL run March C- over all N addresses: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-017 Data 0 SHALL be all zeros and data 1 all ones; each op SHALL take exactly one cycle with MEN=1; reads SHALL drive WEN=0, REN=1; writes WEN=1, REN=0.
REQ-018 States: IDLE, RUN, DRAIN, DONE; A_START is accepted only in IDLE or DONE and is ignored in RUN/DRAIN.
REQ-019 Start accepted at edge t: the first op SHALL be presented in cycle t+1 and the last op in cycle t+10N.
REQ-020 The address SHALL count up from 0 to N-1, or down from N-1 to 0, and wrap to the next element's start address with no idle cycle.
REQ-021 Each read SHALL register its expected word and compare it with A_DOUT in the next cycle; any mismatch SHALL set A_FAIL.
REQ-022 The block SHALL enter DRAIN after the last op (one cycle, final compare) and then DONE; A_DONE SHALL rise at cycle t+10N+2.
REQ-023 A_BUSY SHALL be high in RUN and DRAIN; A_BIST_EN SHALL be high in RUN and DRAIN and low in IDLE and DONE.
REQ-024 MEN, WEN and REN SHALL be 0 in every cycle without an op (DRAIN, IDLE, DONE).
REQ-025 A start accepted in DONE SHALL clear A_FAIL and A_DONE in the same edge.

Reset
REQ-026 A_RST SHALL force IDLE with all outputs 0, including A_BIST_BM (all zeros).
REQ-027 Reset mid-test SHALL abort immediately with no further SRAM ops; the next start SHALL restart from E0.

Configuration
REQ-028 Macro SRAM_BIST_FAIL_LOG_EN, when defined, SHALL add outputs A_FAIL_ADDR (P_ADDR_WIDTH), A_FAIL_ELEM (3) and A_FAIL_BITS (P_DATA_WIDTH = expected XOR actual) capturing the first mismatch only, reset to 0 and cleared on start.
REQ-029 Without the macro, these ports and registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the state enum, the element index constants E0..E5, and per-element op tables (direction, op count, read/write data values).
REQ-031 One sub-module, sram_bist_cmp, SHALL hold the expected-data pipeline register, the comparator, the sticky fail flag and the optional fail log.

Verification (P_ADDR_WIDTH=4, P_DATA_WIDTH=8, N=16)
REQ-032 Start pulse with an ideal SRAM model -> A_DONE=1 at t+162, A_FAIL=0, 160 op cycles observed.
REQ-033 Bit 3 of address 5 stuck-at-1 -> A_FAIL=1; with the macro, A_FAIL_ADDR=5, A_FAIL_ELEM=1, A_FAIL_BITS=8'h08.
REQ-034 Start held high through the test -> exactly one run; a re-pulse in DONE restarts the test and clears A_FAIL in the same edge.
REQ-035 A_RST asserted at cycle t+50 -> MEN/WEN/REN/A_BIST_EN=0 in the same cycle; a new start yields a full clean run.
REQ-036 Address trace check -> E3/E4 addresses go 15 down to 0; element boundaries have no gap cycle; the E5 last read at address 15 is compared in DRAIN.
